// File: rtl/mem_responder.sv
// mem_responder: memory-side responder behind the MAR/MDR path.
// It accepts one word request at a time and commits it to an internal
// synchronous RAM after a programmable number of wait states. Completion is
// signalled with a one-cycle ack, and a rejected request gets a one-cycle err.
module mem_responder #(
  parameter int AW          = 15,
  parameter int DW          = 16,
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic          we,
  output logic [DW-1:0] rdata,
  output logic          ack,
  output logic          busy,
  output logic          err
);

  // Only the low log2(DEPTH) address bits index the array. The range check
  // below still looks at every address bit.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // DEPTH is at most 2^AW, so it fits in AW+1 bits. The extra bit keeps the
  // compare unsigned and free of truncation.
  localparam logic [AW:0] depth_lim = (AW + 1)'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t          state_reg;
  logic [3:0]      cnt_reg;
  logic [IW-1:0]   idx_reg;
  logic [DW-1:0]   wdata_reg;
  logic            wr_reg;
  logic            ack_reg;
  logic            busy_reg;
  logic            err_reg;
  logic [DW-1:0]   rdata_reg;

  logic [DW-1:0]   mem [0:DEPTH-1];

  logic            req;
  logic            reject;
  logic            commit;

  assign req    = re | we;
  assign reject = (re & we) | ({1'b0, addr} >= depth_lim);

  // The access commits on the edge at which the wait counter has already
  // reached zero. A reset on that same edge abandons the access.
  assign commit = !rst && (state_reg == WAIT) && (cnt_reg == 4'd0);

  // Request FSM. It accepts or rejects a request in IDLE, and in WAIT it
  // counts down and then completes with ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      idx_reg   <= '0;
      wdata_reg <= '0;
      wr_reg    <= 1'b0;
      ack_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      ack_reg <= 1'b0;
      err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req) begin
            if (reject) begin
              err_reg <= 1'b1;
            end else begin
              idx_reg   <= addr[IW-1:0];
              wdata_reg <= wdata;
              wr_reg    <= we;
              cnt_reg   <= 4'(WAIT_STATES);
              busy_reg  <= 1'b1;
              state_reg <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            ack_reg   <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // RAM write port. There is no reset here, so the contents survive rst.
  always_ff @(posedge clk) begin
    if (commit && wr_reg) begin
      mem[idx_reg] <= wdata_reg;
    end
  end

  // Registered RAM read. rdata changes only on a completed read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg <= '0;
    end else if (commit && !wr_reg) begin
      rdata_reg <= mem[idx_reg];
    end
  end

  assign rdata = rdata_reg;
  assign ack   = ack_reg;
  assign busy  = busy_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and random requests against two responders,
// one with WAIT_STATES=2 and one with WAIT_STATES=0. A word-array model and
// a last-read register give the expected values. Timing comes from the
// request/ack latency rule.
module tb_mem_responder;

  localparam int WS_A = 2;
  localparam int WS_B = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_re, a_we, b_re, b_we;
  logic [15:0] a_rdata, b_rdata;
  logic        a_ack, a_busy, a_err, b_ack, b_busy, b_err;

  int total = 0;
  int bad   = 0;

  // Selects which instance the generic request task observes.
  bit          cur = 1'b0;
  logic [15:0] o_rdata;
  logic        o_ack, o_busy, o_err;
  assign o_rdata = cur ? b_rdata : a_rdata;
  assign o_ack   = cur ? b_ack   : a_ack;
  assign o_busy  = cur ? b_busy  : a_busy;
  assign o_err   = cur ? b_err   : a_err;

  // Model: expected memory contents and the last completed read of each
  // instance.
  logic [15:0] ref_mem [2][4096];
  logic [15:0] last_rd [2];
  int          ws [2];

  always #5 clk = ~clk;

  mem_responder #(.AW(15), .DW(16), .DEPTH(4096), .WAIT_STATES(WS_A)) dut_a (
    .clk(clk), .rst(rst), .addr(a_addr), .wdata(a_wdata), .re(a_re), .we(a_we),
    .rdata(a_rdata), .ack(a_ack), .busy(a_busy), .err(a_err)
  );

  mem_responder #(.AW(15), .DW(16), .DEPTH(4096), .WAIT_STATES(WS_B)) dut_b (
    .clk(clk), .rst(rst), .addr(b_addr), .wdata(b_wdata), .re(b_re), .we(b_we),
    .rdata(b_rdata), .ack(b_ack), .busy(b_busy), .err(b_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit s, input logic r, input logic w,
                        input logic [14:0] a, input logic [15:0] d);
    if (s) begin
      b_re = r; b_we = w; b_addr = a; b_wdata = d;
    end else begin
      a_re = r; a_we = w; a_addr = a; a_wdata = d;
    end
  endtask

  // Inputs driven while busy. mode 1 drives random inputs. mode 2 drives a
  // write of FFFF to address 8.
  task automatic disturb(input bit s, input int mode);
    if (mode == 1)
      set_in(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             15'($urandom_range(0, 32767)), 16'($urandom));
    else if (mode == 2)
      set_in(s, 1'b0, 1'b1, 15'd8, 16'hFFFF);
  endtask

  // Presents one request for one edge and checks the whole handshake. A
  // legal request keeps busy high for ws+1 edges and then gives one ack
  // cycle. An illegal request gives one err cycle.
  task automatic do_req(input bit s, input logic r, input logic w,
                        input logic [14:0] a, input logic [15:0] d,
                        input int dmode, input string tag);
    bit legal;
    legal = (r || w) && !(r && w) && (a < 15'd4096);
    cur = s;
    set_in(s, r, w, a, d);
    tick();
    set_in(s, 1'b0, 1'b0, 15'd0, 16'd0);
    if (!legal) begin
      chk1({tag, "/err"}, o_err, 1'b1);
      chk1({tag, "/ack0"}, o_ack, 1'b0);
      chk1({tag, "/busy0"}, o_busy, 1'b0);
      chk16({tag, "/rdata_hold"}, o_rdata, last_rd[s]);
      tick();
      chk1({tag, "/err_drop"}, o_err, 1'b0);
      chk1({tag, "/ack_none"}, o_ack, 1'b0);
      $display("%s sel=%0d re=%0b we=%0b addr=%h rejected", tag, s, r, w, a);
      return;
    end
    chk1({tag, "/busy"}, o_busy, 1'b1);
    chk1({tag, "/ack_early"}, o_ack, 1'b0);
    chk1({tag, "/err0"}, o_err, 1'b0);
    for (int k = 0; k < ws[s]; k++) begin
      disturb(s, dmode);
      tick();
      chk1({tag, "/wait_busy"}, o_busy, 1'b1);
      chk1({tag, "/wait_ack"}, o_ack, 1'b0);
      chk1({tag, "/wait_err"}, o_err, 1'b0);
      chk16({tag, "/wait_rdata"}, o_rdata, last_rd[s]);
    end
    disturb(s, dmode);
    tick();
    set_in(s, 1'b0, 1'b0, 15'd0, 16'd0);
    if (w) ref_mem[s][a[11:0]] = d;
    else   last_rd[s] = ref_mem[s][a[11:0]];
    chk1({tag, "/ack"}, o_ack, 1'b1);
    chk1({tag, "/busy_drop"}, o_busy, 1'b0);
    chk1({tag, "/err_ack"}, o_err, 1'b0);
    chk16({tag, "/rdata"}, o_rdata, last_rd[s]);
    tick();
    chk1({tag, "/ack_pulse"}, o_ack, 1'b0);
    chk1({tag, "/idle_busy"}, o_busy, 1'b0);
    $display("%s sel=%0d %s addr=%h wdata=%h rdata=%h", tag, s, w ? "WR" : "RD",
             a, d, o_rdata);
  endtask

  initial begin
    logic [14:0] acc_addr;
    ws[0] = WS_A;
    ws[1] = WS_B;
    last_rd[0] = 16'h0;
    last_rd[1] = 16'h0;

    // 1. Reset held with re asserted: every output stays low.
    rst = 1'b1;
    set_in(0, 1'b1, 1'b0, 15'd1, 16'd0);
    set_in(1, 1'b1, 1'b0, 15'd1, 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk16("rst/a_rdata", a_rdata, 16'h0);
      chk1("rst/a_ack", a_ack, 1'b0);
      chk1("rst/a_busy", a_busy, 1'b0);
      chk1("rst/a_err", a_err, 1'b0);
      chk16("rst/b_rdata", b_rdata, 16'h0);
      chk1("rst/b_ack", b_ack, 1'b0);
      chk1("rst/b_busy", b_busy, 1'b0);
      $display("reset cycle %0d", i);
    end
    set_in(0, 1'b0, 1'b0, 15'd0, 16'd0);
    set_in(1, 1'b0, 1'b0, 15'd0, 16'd0);
    rst = 1'b0;
    tick();

    // 2. Write, then read back.
    do_req(0, 1'b0, 1'b1, 15'h0010, 16'hBEEF, 0, "wr10");
    do_req(0, 1'b1, 1'b0, 15'h0010, 16'h0000, 0, "rd10");

    // 3. Illegal requests and the address boundary.
    do_req(0, 1'b1, 1'b1, 15'd5, 16'h1111, 0, "both");
    do_req(0, 1'b1, 1'b0, 15'h1000, 16'h0000, 0, "oob_depth");
    do_req(0, 1'b0, 1'b1, 15'h7FFF, 16'h2222, 0, "oob_max");
    do_req(0, 1'b0, 1'b1, 15'h0FFF, 16'hC0DE, 0, "wr_last");
    do_req(0, 1'b1, 1'b0, 15'h0FFF, 16'h0000, 0, "rd_last");

    // 4. Inputs that change while busy are ignored.
    do_req(0, 1'b0, 1'b1, 15'd8, 16'h0F0F, 0, "pre8");
    do_req(0, 1'b0, 1'b1, 15'd7, 16'h1234, 2, "wr7_dist");
    do_req(0, 1'b1, 1'b0, 15'd8, 16'h0000, 0, "rd8");
    do_req(0, 1'b1, 1'b0, 15'd7, 16'h0000, 0, "rd7");

    // 5. Reset on the commit edge of a write abandons the write.
    do_req(0, 1'b0, 1'b1, 15'd3, 16'h5555, 0, "pre3");
    cur = 1'b0;
    set_in(0, 1'b0, 1'b1, 15'd3, 16'hAAAA);
    tick();
    set_in(0, 1'b0, 1'b0, 15'd0, 16'd0);
    chk1("midrst/busy", a_busy, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk1("midrst/ack", a_ack, 1'b0);
    chk1("midrst/busy", a_busy, 1'b0);
    chk16("midrst/rdata", a_rdata, 16'h0);
    rst = 1'b0;
    last_rd[0] = 16'h0;
    last_rd[1] = 16'h0;
    tick();
    chk1("midrst/ack_after", a_ack, 1'b0);
    $display("reset during write to addr 3");
    do_req(0, 1'b1, 1'b0, 15'd3, 16'h0000, 0, "rd3");

    // 6. Back-to-back reads with no wait states and re held high.
    do_req(1, 1'b0, 1'b1, 15'd1, 16'hA1A1, 0, "b_pre1");
    do_req(1, 1'b0, 1'b1, 15'd2, 16'hB2B2, 0, "b_pre2");
    cur = 1'b1;
    acc_addr = 15'd1;
    set_in(1, 1'b1, 1'b0, 15'd1, 16'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i % 2 == 0) begin
        acc_addr = b_addr;
        chk1("b2b/ack_off", b_ack, 1'b0);
        chk1("b2b/busy_on", b_busy, 1'b1);
        set_in(1, 1'b1, 1'b0, (b_addr == 15'd1) ? 15'd2 : 15'd1, 16'd0);
      end else begin
        last_rd[1] = ref_mem[1][acc_addr[11:0]];
        chk1("b2b/ack_on", b_ack, 1'b1);
        chk1("b2b/busy_off", b_busy, 1'b0);
        chk16("b2b/rdata", b_rdata, last_rd[1]);
        $display("b2b read addr=%h rdata=%h", acc_addr, b_rdata);
      end
    end
    set_in(1, 1'b0, 1'b0, 15'd0, 16'd0);
    tick();
    chk1("b2b/ack_end", b_ack, 1'b0);

    // Random traffic on both instances after preloading 16 words.
    for (int i = 0; i < 16; i++) begin
      do_req(0, 1'b0, 1'b1, 15'(i), 16'($urandom), 0, "rnd_pre_a");
      do_req(1, 1'b0, 1'b1, 15'(i), 16'($urandom), 0, "rnd_pre_b");
    end
    for (int i = 0; i < 60; i++) begin
      int  kind;
      bit  s;
      s    = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      if (kind == 0)
        do_req(s, 1'b1, 1'b1, 15'($urandom_range(0, 32767)), 16'($urandom), 0, "rnd_both");
      else if (kind == 1)
        do_req(s, 1'($urandom_range(0, 1)), 1'b1, 15'($urandom_range(4096, 32767)),
               16'($urandom), 0, "rnd_oob");
      else if (kind < 6)
        do_req(s, 1'b1, 1'b0, 15'($urandom_range(0, 15)), 16'd0,
               $urandom_range(0, 1), "rnd_rd");
      else
        do_req(s, 1'b0, 1'b1, 15'($urandom_range(0, 15)), 16'($urandom),
               $urandom_range(0, 1), "rnd_wr");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
